// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle IEEE-754 single divider. One shared multiplier and one shared adder
// are sequenced by an FSM through Newton-Raphson reciprocal refinement, then A * (1/B).
module div_seq_ctrl #(
  parameter int unsigned ITERATIONS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero_division
);

  generate
    if (ITERATIONS < 1 || ITERATIONS > 4) begin : gBadIterations
      $error("div_seq_ctrl: ITERATIONS must be in 1..4");
    end
  endgenerate

  // Truncating multiply, no denormals; zero operands flush to signed zero.
  function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [9:0]  e;
    logic [31:0] r;
    s = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'd0, p[47]};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      r = {s, 8'hFF, (a[30:23] == 8'hFF) ? a[22:0] : b[22:0]};
    else if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || e[9] || e == 10'd0)
      r = {s, 31'd0};
    else if (e >= 10'd255)
      r = {s, 8'hFF, 23'd0};
    else
      r = {s, e[7:0], 23'(p >> (p[47] ? 6'd24 : 6'd23))};
    return r;
  endfunction

  // Truncating add: the smaller operand is aligned by a plain right shift (bits dropped).
  function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  d;
    logic [23:0] mLo;
    logic [23:0] diff;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic [31:0] r;
    if (a[30:0] >= b[30:0]) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    d    = hi[30:23] - lo[30:23];
    mLo  = (lo[30:23] == 8'h00 || d > 8'd23) ? 24'd0 : ({1'b1, lo[22:0]} >> d);
    sum  = {1'b0, 1'b1, hi[22:0]} + {1'b0, mLo};
    diff = {1'b1, hi[22:0]} - mLo;
    lz   = 5'd0;
    for (int unsigned i = 0; i < 24; i++)
      if (diff[i]) lz = 5'(23 - i);
    if (hi[30:23] == 8'h00)
      r = '0;
    else if (hi[30:23] == 8'hFF)
      r = hi;
    else if (hi[31] == lo[31]) begin
      if (!sum[24])
        r = {hi[31], hi[30:23], sum[22:0]};
      else if (hi[30:23] == 8'hFE)
        r = {hi[31], 8'hFF, 23'd0};
      else
        r = {hi[31], hi[30:23] + 8'd1, sum[23:1]};
    end else if (diff == 24'd0 || {3'b000, lz} >= hi[30:23])
      r = '0;
    else
      r = {hi[31], hi[30:23] - {3'b000, lz}, 23'(diff << lz)};
    return r;
  endfunction

  typedef enum logic [2:0] {IDLE, SEED_M, SEED_A, IT_M1, IT_A, IT_M2, FINAL} state_e;

  state_e      state;
  state_e      stateNext;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] x;
  logic [31:0] t;
  logic [2:0]  iterCnt;
  logic [31:0] bm;
  logic [31:0] recip;
  logic [31:0] mulA;
  logic [31:0] mulB;
  logic [31:0] mulY;
  logic [31:0] addA;
  logic [31:0] addB;
  logic [31:0] addY;
  logic        accept;
  logic        lastIter;

  assign accept   = start && (state == IDLE);
  assign busy     = (state != IDLE);
  assign bm       = {1'b0, 8'd126, opB[22:0]};
  // x is the reciprocal of bm; undo the mantissa scaling in the exponent (8-bit wrap)
  assign recip    = {opB[31] ^ x[31], 8'(x[30:23] + 8'd126 - opB[30:23]), x[22:0]};
  assign lastIter = ({29'd0, iterCnt} + 32'd1) >= ITERATIONS;

  always_comb begin
    stateNext = state;
    mulA      = '0;
    mulB      = '0;
    addA      = '0;
    addB      = '0;
    case (state)
      IDLE:    if (start) stateNext = SEED_M;
      SEED_M:  begin mulA = bm;           mulB = 32'h3FF0F0F1;          stateNext = SEED_A; end
      SEED_A:  begin addA = 32'h4034B4B5; addB = {1'b1, t[30:0]};       stateNext = IT_M1;  end
      IT_M1:   begin mulA = bm;           mulB = x;                     stateNext = IT_A;   end
      IT_A:    begin addA = 32'h40000000; addB = {~t[31], t[30:0]};     stateNext = IT_M2;  end
      IT_M2:   begin
        mulA      = x;
        mulB      = t;
        stateNext = lastIter ? FINAL : IT_M1;
      end
      FINAL:   begin mulA = opA;          mulB = recip;                 stateNext = IDLE;   end
      default: stateNext = IDLE;
    endcase
    mulY = fpMul(mulA, mulB);
    addY = fpAdd(addA, addB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      opA           <= '0;
      opB           <= '0;
      x             <= '0;
      t             <= '0;
      iterCnt       <= '0;
      done          <= 1'b0;
      result        <= '0;
      zero_division <= 1'b0;
    end else begin
      state <= stateNext;
      done  <= 1'b0;
      if (accept) begin
        opA     <= A;
        opB     <= B;
        iterCnt <= '0;
      end
      case (state)
        SEED_M, IT_M1: t <= mulY;
        IT_A:          t <= addY;
        SEED_A:        x <= addY;
        IT_M2: begin
          x       <= mulY;
          iterCnt <= iterCnt + 3'd1;
        end
        FINAL: begin
          result        <= (opA[30:23] == 8'h00 || opB[30:23] == 8'h00) ? '0 : mulY;
          zero_division <= (opB[30:23] == 8'h00);
          done          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl: latency, handshake, zero handling, reset abort.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero_division;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned lat;
  int unsigned lat2;
  int unsigned doneCnt;
  logic        busyAll;
  logic        held;
  logic [31:0] firstRes;

  div_seq_ctrl #(.ITERATIONS(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .A             (A),
    .B             (B),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .zero_division (zero_division)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic opStart(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; bounded at 30 edges.
  task automatic waitDone(output int unsigned latOut, output logic busyOut, output logic heldOut);
    logic [31:0] r0;
    r0      = result;
    latOut  = 0;
    busyOut = 1'b1;
    heldOut = 1'b1;
    for (int unsigned n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        latOut = n;
        break;
      end
      if (!busy) busyOut = 1'b0;
      if (result !== r0) heldOut = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    checkVal("rst_done", {31'd0, done}, 32'd0);
    checkVal("rst_result", result, 32'd0);
    checkVal("rst_zdiv", {31'd0, zero_division}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6.0 / 2.0
    opStart(32'h40C00000, 32'h40000000);
    checkVal("t1_busy_on_accept", {31'd0, busy}, 32'd1);
    waitDone(lat, busyAll, held);
    checkVal("t1_latency", lat, 32'd12);
    checkVal("t1_busy_throughout", {31'd0, busyAll}, 32'd1);
    checkVal("t1_busy_low_at_done", {31'd0, busy}, 32'd0);
    checkVal("t1_result_in_set", {31'd0, (result == 32'h40400000 || result == 32'h403FFFFF)}, 32'd1);
    checkVal("t1_zdiv", {31'd0, zero_division}, 32'd0);
    @(posedge clk);
    #1;
    checkVal("t1_done_one_cycle", {31'd0, done}, 32'd0);

    // -1.0 / 4.0
    opStart(32'hBF800000, 32'h40800000);
    waitDone(lat, busyAll, held);
    checkVal("t2_latency", lat, 32'd12);
    checkVal("t2_busy_throughout", {31'd0, busyAll}, 32'd1);
    checkVal("t2_result_in_set", {31'd0, (result == 32'hBE800000 || result == 32'hBE7FFFFF)}, 32'd1);

    // 1.0 / 0.0, then 1.0 / 1.0 clears the flag
    opStart(32'h3F800000, 32'h00000000);
    waitDone(lat, busyAll, held);
    checkVal("t3_latency", lat, 32'd12);
    checkVal("t3_result", result, 32'd0);
    checkVal("t3_zdiv", {31'd0, zero_division}, 32'd1);
    opStart(32'h3F800000, 32'h3F800000);
    waitDone(lat, busyAll, held);
    checkVal("t3b_zdiv", {31'd0, zero_division}, 32'd0);
    checkVal("t3b_result_in_set", {31'd0, (result == 32'h3F800000 || result == 32'h3F7FFFFF)}, 32'd1);

    // 0.0 / 2.0 with a start pulse mid-operation that must be ignored
    opStart(32'h00000000, 32'h40000000);
    doneCnt = 0;
    lat     = 0;
    for (int unsigned n = 1; n <= 30; n++) begin
      if (n == 4) begin
        A     = 32'h3F800000;
        B     = 32'h3F800000;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        doneCnt++;
        if (lat == 0) lat = n;
      end
    end
    checkVal("t4_latency", lat, 32'd12);
    checkVal("t4_done_count", doneCnt, 32'd1);
    checkVal("t4_result", result, 32'd0);
    checkVal("t4_zdiv", {31'd0, zero_division}, 32'd0);

    // back-to-back: restart in the done cycle
    opStart(32'h40C00000, 32'h40000000);
    waitDone(lat, busyAll, held);
    checkVal("t5_latency1", lat, 32'd12);
    firstRes = result;
    A     = 32'h41200000;
    B     = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkVal("t5_busy_after_restart", {31'd0, busy}, 32'd1);
    checkVal("t5_first_in_set", {31'd0, (firstRes == 32'h40400000 || firstRes == 32'h403FFFFF)}, 32'd1);
    waitDone(lat2, busyAll, held);
    checkVal("t5_latency2", lat2, 32'd12);
    checkVal("t5_first_held", {31'd0, held}, 32'd1);
    checkVal("t5_result2_in_set", {31'd0, (result == 32'h40A00000 || result == 32'h409FFFFF)}, 32'd1);

    // asynchronous reset mid-operation
    opStart(32'h3F800000, 32'h40000000);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("t6_busy_in_reset", {31'd0, busy}, 32'd0);
    checkVal("t6_done_in_reset", {31'd0, done}, 32'd0);
    checkVal("t6_result_in_reset", result, 32'd0);
    checkVal("t6_zdiv_in_reset", {31'd0, zero_division}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    doneCnt = 0;
    for (int unsigned n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done) doneCnt++;
    end
    checkVal("t6_no_done_after_abort", doneCnt, 32'd0);
    opStart(32'h40C00000, 32'h40000000);
    waitDone(lat, busyAll, held);
    checkVal("t6_fresh_latency", lat, 32'd12);
    checkVal("t6_fresh_result_in_set", {31'd0, (result == 32'h40400000 || result == 32'h403FFFFF)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
